// File: rtl/button_event_scheduler_pkg.sv
// Shared encodings for the button event scheduler: event codes, per-button FSM
// states and the counter width rule.
package button_event_scheduler_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_LONG    = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_HELD,
    ST_DEB_REL
  } btn_state_e;

  // One spare bit above the largest terminal count lets counters saturate cleanly.
  function automatic int cnt_width(input int long_c, input int rep_c, input int deb_c);
    int m;
    m = long_c;
    if (rep_c > m) m = rep_c;
    if (deb_c > m) m = deb_c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Pad-side button levels in, classified event channel and debounced levels out.
interface button_event_scheduler_if #(
  parameter int N_BTN = 4
) ();
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] button_in;
  logic             event_valid;
  logic [ID_W-1:0]  event_id;
  logic [1:0]       event_type;
  logic [N_BTN-1:0] btn_level;

  modport master (
    input  button_in,
    output event_valid, event_id, event_type, btn_level
  );

  modport slave (
    output button_in,
    input  event_valid, event_id, event_type, btn_level
  );
endinterface

// File: rtl/button_event_scheduler_btn_press_fsm.sv
// One button: 2-flop synchroniser, debounce/hold/repeat FSM, debounced level and
// a single-cycle raise strobe carrying the event type.
module btn_press_fsm
  import button_event_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_button,
  output logic       o_raise,
  output logic [1:0] o_raise_type,
  output logic       o_level
);
  localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       r_sync;
  logic             w_s;
  btn_state_e       r_state, w_state_nxt;
  btn_state_e       r_origin, w_origin_nxt;
  logic [CNT_W-1:0] r_deb_cnt, w_deb_cnt_nxt;
  logic [CNT_W-1:0] r_time_cnt, w_time_cnt_nxt;
  logic             r_level, w_level_nxt;

  assign w_s     = r_sync[1];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_state    <= ST_IDLE;
      r_origin   <= ST_PRESSED;
      r_deb_cnt  <= '0;
      r_time_cnt <= '0;
      r_level    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_button};
      r_state    <= w_state_nxt;
      r_origin   <= w_origin_nxt;
      r_deb_cnt  <= w_deb_cnt_nxt;
      r_time_cnt <= w_time_cnt_nxt;
      r_level    <= w_level_nxt;
    end
  end

  // r_time_cnt is the hold counter in PRESSED and the repeat counter in HELD;
  // it is left untouched while a release is being debounced so a bounce resumes it.
  always_comb begin
    w_state_nxt    = r_state;
    w_origin_nxt   = r_origin;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_time_cnt_nxt = r_time_cnt;
    w_level_nxt    = r_level;
    o_raise        = 1'b0;
    o_raise_type   = EV_PRESS;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt   = ST_DEB_PRESS;
          w_deb_cnt_nxt = CNT_ONE;
        end
      end
      ST_DEB_PRESS: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
        end else if (sat_inc(r_deb_cnt) >= DEB_MAX) begin
          w_state_nxt    = ST_PRESSED;
          w_deb_cnt_nxt  = sat_inc(r_deb_cnt);
          w_time_cnt_nxt = '0;
          w_level_nxt    = 1'b1;
          o_raise        = 1'b1;
          o_raise_type   = EV_PRESS;
        end else begin
          w_deb_cnt_nxt = sat_inc(r_deb_cnt);
        end
      end
      ST_PRESSED, ST_HELD: begin
        if (!w_s) begin
          w_state_nxt   = ST_DEB_REL;
          w_origin_nxt  = r_state;
          w_deb_cnt_nxt = CNT_ONE;
        end else if ((r_state == ST_PRESSED) && (sat_inc(r_time_cnt) >= LONG_MAX)) begin
          w_state_nxt    = ST_HELD;
          w_time_cnt_nxt = '0;
          o_raise        = 1'b1;
          o_raise_type   = EV_LONG;
        end else if ((r_state == ST_HELD) && (sat_inc(r_time_cnt) >= REP_MAX)) begin
          w_time_cnt_nxt = '0;
          o_raise        = 1'b1;
          o_raise_type   = EV_REPEAT;
        end else begin
          w_time_cnt_nxt = sat_inc(r_time_cnt);
        end
      end
      ST_DEB_REL: begin
        if (w_s) begin
          w_state_nxt = r_origin;
        end else if (sat_inc(r_deb_cnt) >= DEB_MAX) begin
          w_state_nxt   = ST_IDLE;
          w_deb_cnt_nxt = sat_inc(r_deb_cnt);
          w_level_nxt   = 1'b0;
          o_raise       = 1'b1;
          o_raise_type  = EV_RELEASE;
        end else begin
          w_deb_cnt_nxt = sat_inc(r_deb_cnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/button_event_scheduler.sv
// N per-button FSMs feeding one pending slot each; a round-robin arbiter drains
// the slots onto a single registered event channel.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic                     clk,
  input  logic                     reset,
  button_event_scheduler_if.master bus
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] w_raise;
  logic [1:0]       w_raise_type [N_BTN];
  logic [N_BTN-1:0] w_level;

  logic [N_BTN-1:0] r_pend_vld;
  logic [1:0]       r_pend_type [N_BTN];
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_ev_valid;
  logic [ID_W-1:0]  r_ev_id;
  logic [1:0]       r_ev_type;

  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_idx;
  logic [ID_W-1:0]  w_cand;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_press_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_fsm (
      .clk         (clk),
      .reset       (reset),
      .i_button    (bus.button_in[g]),
      .o_raise     (w_raise[g]),
      .o_raise_type(w_raise_type[g]),
      .o_level     (w_level[g])
    );
  end

  // First pending slot at or after r_rr_ptr, wrapping modulo N_BTN.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % N_BTN);
      if (!w_grant_vld && r_pend_vld[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // A raise landing on the slot being granted wins: the grant ships the old type
  // and the slot stays valid with the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld <= '0;
      r_rr_ptr   <= '0;
      r_ev_valid <= 1'b0;
      r_ev_id    <= '0;
      r_ev_type  <= '0;
      for (int b = 0; b < N_BTN; b++) r_pend_type[b] <= '0;
    end else begin
      r_ev_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_ev_id   <= w_grant_idx;
        r_ev_type <= r_pend_type[w_grant_idx];
        r_rr_ptr  <= ID_W'((int'(w_grant_idx) + 1) % N_BTN);
      end
      for (int b = 0; b < N_BTN; b++) begin
        if (w_raise[b]) begin
          r_pend_vld[b]  <= 1'b1;
          r_pend_type[b] <= w_raise_type[b];
        end else if (w_grant_vld && (w_grant_idx == ID_W'(b))) begin
          r_pend_vld[b] <= 1'b0;
        end
      end
    end
  end

  assign bus.event_valid = r_ev_valid;
  assign bus.event_id    = r_ev_id;
  assign bus.event_type  = r_ev_type;
  assign bus.btn_level   = w_level;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench: each stimulus step queues the events it must cause, with the
// exact cycle they must appear; a negedge monitor pops and compares them.
module tb_button_event_scheduler;
  import button_event_scheduler_pkg::*;

  localparam int N_BTN = 4;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int REP   = 8;
  localparam int LAT   = DEB + 3;

  logic clk = 1'b0;
  logic reset;
  logic mon_en;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int id;
    int typ;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  button_event_scheduler_if #(.N_BTN(N_BTN)) bus ();

  button_event_scheduler #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int id, input int typ, input int at);
    exp_t x;
    x.id  = id;
    x.typ = typ;
    x.at  = at;
    sb.push_back(x);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus.event_valid !== 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'(bus.event_valid), 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("ev_valid", 32'(bus.event_valid), 32'd1);
        check("ev_id",    32'(bus.event_id),    32'(m_e.id));
        check("ev_type",  32'(bus.event_type),  32'(m_e.typ));
        check("ev_cycle", 32'(cyc),             32'(m_e.at));
      end
    end
  end

  initial begin
    int c;
    mon_en        = 1'b0;
    reset         = 1'b1;
    bus.button_in = '0;
    tick(3);
    check("rst_valid", 32'(bus.event_valid), 32'd0);
    check("rst_id",    32'(bus.event_id),    32'd0);
    check("rst_type",  32'(bus.event_type),  32'd0);
    check("rst_level", 32'(bus.btn_level),   32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(5);

    // Clean press / release on btn0, too short for LONG
    c = cyc;
    bus.button_in[0] = 1'b1;
    push(0, EV_PRESS, c + LAT);
    tick(8);
    check("t1_level_hi", 32'(bus.btn_level[0]), 32'd1);
    tick(4);
    bus.button_in[0] = 1'b0;
    push(0, EV_RELEASE, cyc + LAT);
    tick(8);
    check("t1_level_lo", 32'(bus.btn_level[0]), 32'd0);
    tick(30);
    check("t1_drained", 32'(sb.size()), 32'd0);

    // Bouncing btn1 never debounces
    for (int k = 0; k < 10; k++) begin
      bus.button_in[1] = (k % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick(1);
        check("t2_level", 32'(bus.btn_level[1]), 32'd0);
      end
    end
    bus.button_in[1] = 1'b0;
    tick(12);
    check("t2_level_end", 32'(bus.btn_level[1]), 32'd0);

    // Long hold on btn2: PRESS, LONG, four REPEATs, RELEASE
    c = cyc;
    bus.button_in[2] = 1'b1;
    push(2, EV_PRESS, c + LAT);
    push(2, EV_LONG, c + LAT + LONG);
    for (int r = 1; r <= 4; r++) push(2, EV_REPEAT, c + LAT + LONG + r * REP);
    tick(30);
    check("t3_level_hi", 32'(bus.btn_level[2]), 32'd1);
    tick(30);
    bus.button_in[2] = 1'b0;
    push(2, EV_RELEASE, cyc + LAT);
    tick(15);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // btn3 in HELD dips low for 2 cycles: no RELEASE, repeat delayed by 3 frozen cycles
    c = cyc;
    bus.button_in[3] = 1'b1;
    push(3, EV_PRESS, c + LAT);
    push(3, EV_LONG, c + LAT + LONG);
    push(3, EV_REPEAT, c + LAT + LONG + REP);
    tick(38);
    bus.button_in[3] = 1'b0;
    tick(2);
    bus.button_in[3] = 1'b1;
    push(3, EV_REPEAT, c + LAT + LONG + 2 * REP + 3);
    push(3, EV_REPEAT, c + LAT + LONG + 3 * REP + 3);
    tick(2);
    check("t4_level_dip", 32'(bus.btn_level[3]), 32'd1);
    tick(14);
    bus.button_in[3] = 1'b0;
    push(3, EV_RELEASE, cyc + LAT);
    tick(12);
    check("t4_drained", 32'(sb.size()), 32'd0);

    // All four pressed on the same edge, twice
    for (int round = 0; round < 2; round++) begin
      c = cyc;
      bus.button_in = '1;
      for (int i = 0; i < N_BTN; i++) push(i, EV_PRESS, c + LAT + i);
      tick(10);
      check("t5_level_all", 32'(bus.btn_level), 32'hF);
      bus.button_in = '0;
      for (int i = 0; i < N_BTN; i++) push(i, EV_RELEASE, cyc + LAT + i);
      tick(14);
      check("t5_level_none", 32'(bus.btn_level), 32'd0);
      check("t5_drained", 32'(sb.size()), 32'd0);
    end

    // Reset while btn0 is PRESSED with its PRESS still pending
    c = cyc;
    bus.button_in[0] = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    check("t6_rst_valid", 32'(bus.event_valid), 32'd0);
    check("t6_rst_id",    32'(bus.event_id),    32'd0);
    check("t6_rst_type",  32'(bus.event_type),  32'd0);
    check("t6_rst_level", 32'(bus.btn_level),   32'd0);
    reset = 1'b0;
    push(0, EV_PRESS, cyc + LAT);
    tick(10);
    check("t6_level_hi", 32'(bus.btn_level[0]), 32'd1);
    bus.button_in[0] = 1'b0;
    push(0, EV_RELEASE, cyc + LAT);
    tick(12);
    check("t6_drained", 32'(sb.size()), 32'd0);

    tick(5);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
